// File: rtl/instruction_decoder_pipe_pkg.sv
// Shared types and constants for the nibble-processor instruction decoder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package instruction_decoder_pipe_pkg;

    // Opcode classes recognised in the top bits of an instruction byte
    typedef enum logic [2:0] {
        LOAD,
        MOVE,
        ALU,
        JUMP,
        CONDITIONAL_JUMP
    } instruction_t;

    // EXT_WAIT holds the first byte of a wide LOAD, EXT_EXEC issues it
    typedef enum logic [1:0] {
        EXEC,
        EXT_WAIT,
        EXT_EXEC
    } decode_state_t;

    // Register codes as they appear in LOAD/MOVE fields
    localparam logic [2:0] X0    = 3'd0;
    localparam logic [2:0] X1    = 3'd1;
    localparam logic [2:0] Y0    = 3'd2;
    localparam logic [2:0] Y1    = 3'd3;
    localparam logic [2:0] O_DST = 3'd4;  // code 4 as destination is o_reg
    localparam logic [2:0] R_SRC = 3'd4;  // code 4 as source is r
    localparam logic [2:0] M     = 3'd5;
    localparam logic [2:0] I     = 3'd6;
    localparam logic [2:0] DM    = 3'd7;

    // Bit positions inside reg_en
    localparam int EN_X0    = 0;
    localparam int EN_X1    = 1;
    localparam int EN_Y0    = 2;
    localparam int EN_Y1    = 3;
    localparam int EN_R     = 4;
    localparam int EN_M     = 5;
    localparam int EN_I     = 6;
    localparam int EN_DM    = 7;
    localparam int EN_O_REG = 8;

    localparam int REG_EN_W = 9;

    // Data bus selects
    localparam logic [3:0] SRC_SELF_MOVE      = 4'd9;
    localparam logic [3:0] DEF_NOP_SRC_SEL    = 4'd8;
    localparam logic [3:0] DEF_RESET_SRC_SEL  = 4'd10;

    localparam logic [REG_EN_W-1:0] REG_EN_ALL = 9'h1FF;

endpackage

// File: rtl/instruction_decoder_pipe_instr_class_decode.sv
// Classifies one instruction byte and extracts its register fields.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module instr_class_decode
    import instruction_decoder_pipe_pkg::*;
(
    input  logic [7:0]   instr_byte,
    output instruction_t instr_class,
    output logic [2:0]   dst,
    output logic [2:0]   src
);

    // Class from leading ones, then fields whose position depends on the class
    always_comb begin
        instr_class = LOAD;
        dst         = 3'd0;
        src         = 3'd0;
        if (!instr_byte[7]) begin
            instr_class = LOAD;
            dst         = instr_byte[6:4];
        end else if (!instr_byte[6]) begin
            instr_class = MOVE;
            dst         = instr_byte[5:3];
            src         = instr_byte[2:0];
        end else if (!instr_byte[5]) begin
            instr_class = ALU;
        end else if (!instr_byte[4]) begin
            instr_class = JUMP;
        end else begin
            instr_class = CONDITIONAL_JUMP;
        end
    end

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Captures fetched bytes into ir and decodes register enables, bus select and jump strobes.
// Latency: outputs reflect a captured byte one rising edge after capture (two bytes for wide LOAD).
// Backpressure: stall freezes all state and bubbles outputs; flush squashes ir and any pending wide LOAD.
module instruction_decoder_pipe
    import instruction_decoder_pipe_pkg::*;
#(
    parameter int         DATA_W        = 4,
    parameter logic [3:0] NOP_SRC_SEL   = DEF_NOP_SRC_SEL,
    parameter logic [3:0] RESET_SRC_SEL = DEF_RESET_SRC_SEL
) (
    input  logic              clk,
    input  logic              sync_reset_n,
    input  logic [7:0]        next_instr,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              jmp,
    output logic              jmp_nz,
    output logic [DATA_W-1:0] imm,
    output logic              i_sel,
    output logic              x_sel,
    output logic              y_sel,
    output logic [3:0]        source_sel,
    output logic [8:0]        reg_en,
    output logic [7:0]        ir,
    output logic              busy
);

    // With an 8-bit datapath every LOAD carries a second immediate byte
    localparam bit WIDE_LOAD = (DATA_W == 8);

    logic          ir_valid;
    logic [7:0]    ext;
    decode_state_t state;

    logic [7:0]    decode_byte;
    instruction_t  instr_class;
    logic [2:0]    dst;
    logic [2:0]    src;

    logic [DATA_W-1:0]   imm_dec;
    logic                jmp_dec;
    logic                jmp_nz_dec;
    logic                i_sel_dec;
    logic [3:0]          source_sel_dec;
    logic [REG_EN_W-1:0] reg_en_dec;
    logic                bubble;

    // Instruction register, valid flag and wide-load sequencing
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            ir       <= 8'h00;
            ir_valid <= 1'b0;
            ext      <= 8'h00;
            state    <= EXEC;
        end else if (flush) begin
            // ir keeps its old value; nothing reads it while ir_valid is low
            ir_valid <= 1'b0;
            state    <= EXEC;
        end else if (!stall) begin
            if (instr_valid) begin
                ir       <= next_instr;
                ir_valid <= 1'b1;
                if (state == EXT_WAIT) begin
                    // second byte arrived: park the opcode byte and issue both
                    ext   <= ir;
                    state <= EXT_EXEC;
                end else if (WIDE_LOAD && !next_instr[7]) begin
                    state <= EXT_WAIT;
                end else begin
                    state <= EXEC;
                end
            end else if (state != EXT_WAIT) begin
                // a fetch gap drops the issued instruction but not a pending wide LOAD
                ir_valid <= 1'b0;
                state    <= EXEC;
            end
        end
    end

    // A completing wide LOAD takes its opcode from the parked first byte
    assign decode_byte = (state == EXT_EXEC) ? ext : ir;

    instr_class_decode u_class (
        .instr_byte  (decode_byte),
        .instr_class (instr_class),
        .dst         (dst),
        .src         (src)
    );

    // Immediate: low nibble of ir, with the parked byte's nibble on top for wide LOAD
    generate
        if (DATA_W == 8) begin : g_imm_wide
            assign imm_dec = (state == EXT_EXEC) ? {ext[3:0], ir[3:0]} : {4'h0, ir[3:0]};
        end else begin : g_imm_narrow
            assign imm_dec = ir[3:0];
        end
    endgenerate

    // Per-class decode of the instruction that would issue this cycle
    always_comb begin
        jmp_dec        = 1'b0;
        jmp_nz_dec     = 1'b0;
        i_sel_dec      = 1'b1;
        source_sel_dec = NOP_SRC_SEL;
        reg_en_dec     = '0;
        case (instr_class)
            LOAD: begin
                if (dst == I) begin
                    i_sel_dec = 1'b0;
                end
                if (dst == DM) begin
                    // data-memory writes also advance i
                    reg_en_dec[EN_DM] = 1'b1;
                    reg_en_dec[EN_I]  = 1'b1;
                end else if (dst == O_DST) begin
                    reg_en_dec[EN_O_REG] = 1'b1;
                end else begin
                    reg_en_dec[{1'b0, dst}] = 1'b1;
                end
            end
            MOVE: begin
                if (dst == I) begin
                    i_sel_dec = 1'b0;
                end
                source_sel_dec = (src == dst) ? SRC_SELF_MOVE : {1'b0, src};
                if (dst == O_DST) begin
                    reg_en_dec[EN_O_REG] = 1'b1;
                end else if (dst == I) begin
                    reg_en_dec[EN_I] = 1'b1;
                end else begin
                    reg_en_dec[{1'b0, dst}] = 1'b1;
                    // any data-memory access, read or write, steps i
                    if ((dst == DM) || (src == DM)) begin
                        reg_en_dec[EN_I] = 1'b1;
                    end
                end
            end
            ALU: begin
                reg_en_dec[EN_R] = 1'b1;
            end
            JUMP: begin
                jmp_dec = 1'b1;
            end
            CONDITIONAL_JUMP: begin
                jmp_nz_dec = 1'b1;
            end
            default: begin
                reg_en_dec = '0;
            end
        endcase
    end

    assign bubble = !ir_valid || stall || (state == EXT_WAIT);

    // Output selection: reset pattern, bubble, or the issuing decode
    always_comb begin
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        imm        = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        source_sel = RESET_SRC_SEL;
        reg_en     = REG_EN_ALL;
        if (sync_reset_n) begin
            imm   = imm_dec;
            x_sel = ir[4];
            y_sel = ir[3];
            if (bubble) begin
                i_sel      = 1'b1;
                source_sel = NOP_SRC_SEL;
                reg_en     = '0;
            end else begin
                jmp        = jmp_dec;
                jmp_nz     = jmp_nz_dec;
                i_sel      = i_sel_dec;
                source_sel = source_sel_dec;
                reg_en     = reg_en_dec;
            end
        end
    end

    assign busy = (state == EXT_WAIT);

endmodule

// File: doc/instruction_decoder_pipe.md
Name: instruction_decoder_pipe

Overview:
Second-generation instruction decoder for the 8-bit-opcode nibble processor. It sits between program memory/PC and the datapath. It captures the fetched byte into ir and decodes it into register enables, source select, ALU operand selects and jump strobes. Over gen-1 it adds a fetch-valid handshake, stall and flush, and a DATA_W parameter; DATA_W=8 enables two-byte wide LOAD immediates through a small state machine.

Parameters:
DATA_W, 4, immediate/datapath width; legal values 4 (single-byte LOAD) or 8 (two-byte LOAD).
NOP_SRC_SEL, 4'd8, source_sel driven when no MOVE is issuing.
RESET_SRC_SEL, 4'd10, source_sel driven while in reset.

Ports:
clk  input  1  system clock, all state on rising edge
sync_reset_n  input  1  synchronous reset, active-low
next_instr  input  8  byte from program memory
instr_valid  input  1  next_instr valid this cycle
stall  input  1  hold ir/state; suppress writes and jumps
flush  input  1  squash ir contents (taken jump / redirect)
jmp  output  1  unconditional jump strobe
jmp_nz  output  1  conditional jump strobe
imm  output  DATA_W  LOAD immediate / jump target (low nibble)
i_sel  output  1  0 = i loads from datapath, 1 = i increments
x_sel  output  1  ALU x operand select
y_sel  output  1  ALU y operand select
source_sel  output  4  data bus mux select
reg_en  output  9  [0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]dm [8]o_reg
ir  output  8  current instruction register
busy  output  1  high while in EXT_WAIT

Behaviour:
- Opcode classes on ir: LOAD 0ddd_nnnn; MOVE 10dd_dsss; ALU 110x_y...; JUMP 1110_aaaa; JNZ 1111_aaaa. Register codes 0..7 = x0,x1,y0,y1,o/r,m,i,dm. Code 4 as destination = o_reg (reg_en[8]); as source = r.
- Sequential state: ir, ir_valid, ext byte, state in {EXEC, EXT_WAIT, EXT_EXEC}.
- Edge priority: reset > flush > stall > capture.
  - Reset: ir=8'h00, ir_valid=0, ext=0, state=EXEC.
  - Flush: ir_valid<=0, state<=EXEC; ir value is don't-care.
  - Stall: all state holds.
  - Capture (instr_valid && !stall): ir<=next_instr, ir_valid<=1.
  - Otherwise (no capture, no stall): ir_valid<=0.
- State transitions on capture:
  - DATA_W=8, captured byte is LOAD, state EXEC or EXT_EXEC: go to EXT_WAIT.
  - State EXT_WAIT: ext<=ir, go to EXT_EXEC.
  - Otherwise: go to EXEC.
  - A missing instr_valid while in EXT_WAIT holds EXT_WAIT; ir_valid is kept.
- Outputs are combinational from ir/state (latency 1 edge from capture, as gen-1):
  - sync_reset_n=0: jmp=jmp_nz=0, imm=0, i_sel=x_sel=y_sel=0, source_sel=RESET_SRC_SEL, reg_en=9'h1FF.
  - Bubble (ir_valid=0, or stall=1, or state EXT_WAIT): jmp=jmp_nz=0, reg_en=0, source_sel=NOP_SRC_SEL, i_sel=1; imm/x_sel/y_sel still decode ir.
- Issuing decode (decode instruction is ext in EXT_EXEC, else ir):
  - jmp = JUMP; jmp_nz = JNZ.
  - imm: DATA_W=4: ir[3:0]. DATA_W=8: EXT_EXEC {ext[3:0], ir[3:0]}; otherwise {4'h0, ir[3:0]}.
  - x_sel=ir[4], y_sel=ir[3].
  - i_sel=0 iff LOAD/MOVE dst==6, else 1.
  - source_sel: MOVE with src==dst -> 4'd9; MOVE -> {1'b0,src}; otherwise NOP_SRC_SEL.
  - reg_en, LOAD: dst 7 -> bits 7,6; dst 4 -> bit 8; else bit dst.
  - reg_en, MOVE: dst 4 -> bit 8; dst 6 -> bit 6 only; else bit dst, plus bit 6 if dst==7 or src==7.
  - reg_en, ALU: bit 4. JUMP/JNZ: 0.
- busy=1 only in EXT_WAIT; the PC keeps fetching.
- Reset or flush mid wide-load abandons it; no partial register write.

Decomposition:
- Package defs: instruction_t enum (LOAD, MOVE, ALU, JUMP, CONDITIONAL_JUMP), decode_state_t enum, register-code localparams (X0..DM, O_DST=4, R_SRC=4), reg_en bit indices, constants 9 and NOP/RESET source selects.
- Sub-module instr_class_decode (pure combinational byte -> instruction_t + fields), instantiated once on the decode byte.

Test Plan:
- sync_reset_n=0 two edges -> reg_en=9'h1FF, source_sel=10, jmp=0; release, instr_valid=0 -> reg_en=0, source_sel=8.
- DATA_W=4: capture 8'h35 -> reg_en=9'h008, imm=4'h5, i_sel=1; capture 8'h9F (MOVE dst3 src7) -> reg_en=9'h048, source_sel=7.
- Capture 8'hE9 with stall=1 during decode cycle -> jmp=0, ir holds 8'hE9; stall low -> jmp=1, imm=4'h9; flush edge -> jmp=0 next cycle.
- DATA_W=8: capture 8'h6A, busy=1, reg_en=0; two idle cycles then capture 8'h0C -> reg_en=9'h040, i_sel=0, imm=8'hAC, busy=0.
- DATA_W=8: 8'h6A captured, then flush -> state EXEC, reg_en=0; next 8'hC0 (ALU) -> reg_en=9'h010.
- Reset asserted in EXT_WAIT -> reset pattern; after release 8'h12 yields a new wide load, not a completion.
